norm_round_pipe: RTL and testbench

- Next-generation normalise-and-round back end for the FMA datapath. It sits after the leading-one shifter and before writeback.
- Two-stage pipeline with valid/ready handshake on both sides.
- Fully parametrised in exponent and mantissa width.
- Implements all five RISC-V rounding modes correctly, including RMM and mode-dependent overflow saturation.
- Holds a sticky, accumulated fflags register.

---
 rtl/norm_round_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_norm_round_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_round_pipe.sv
// norm_round_pipe: two-stage normalise-and-round back end for the FMA datapath.
// Stage 1 denormalises tiny results and decodes specials; stage 2 rounds,
// handles overflow saturation and registers the packed result and flags.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   In_valid_i/In_ready_o   input handshake (In_ready_o is combinational)
//   Sign_i, Exp_i, Mant_i, Sticky_i, Rounding_mode_i   unrounded operand
//   Zero_i, Inf_i, NaN_i, Invalid_i   classifier special-case flags
//   Out_valid_o/Out_ready_i  output handshake
//   Result_o            packed {sign, exp, frac}
//   Fflags_o            {NV,DZ,OF,UF,NX} of the current result
//   Fflags_acc_o        sticky accumulation of Fflags_o over handshakes
//   Fflags_clr_i        synchronous clear of the accumulator
module norm_round_pipe #(
  parameter int unsigned PARM_EXP  = 8,
  parameter int unsigned PARM_MANT = 23,
  parameter int unsigned PARM_RM   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          In_valid_i,
  output logic                          In_ready_o,
  input  logic                          Sign_i,
  input  logic [PARM_EXP+1:0]           Exp_i,
  input  logic [PARM_MANT+2:0]          Mant_i,
  input  logic                          Sticky_i,
  input  logic [PARM_RM-1:0]            Rounding_mode_i,
  input  logic                          Zero_i,
  input  logic                          Inf_i,
  input  logic                          NaN_i,
  input  logic                          Invalid_i,
  output logic                          Out_valid_o,
  input  logic                          Out_ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [4:0]                    Fflags_o,
  output logic [4:0]                    Fflags_acc_o,
  input  logic                          Fflags_clr_i
);

  localparam int unsigned W_EI  = PARM_EXP + 2;
  localparam int unsigned W_MI  = PARM_MANT + 3;
  localparam int unsigned W_FGR = PARM_MANT + 2;
  localparam int unsigned W_SH  = PARM_EXP + 3;
  localparam int unsigned W_EF  = PARM_EXP + PARM_MANT;
  localparam int unsigned W_RES = W_EF + 1;

  localparam logic [W_EI-1:0]      EXP_OVF   = W_EI'(2**PARM_EXP - 1);
  localparam logic [PARM_EXP-1:0]  EXP_ONES  = '1;
  localparam logic [PARM_MANT-1:0] QNAN_FRAC = PARM_MANT'(1) << (PARM_MANT - 1);

  localparam logic [PARM_RM-1:0] RM_RTZ = PARM_RM'(1);
  localparam logic [PARM_RM-1:0] RM_RDN = PARM_RM'(2);
  localparam logic [PARM_RM-1:0] RM_RUP = PARM_RM'(3);
  localparam logic [PARM_RM-1:0] RM_RMM = PARM_RM'(4);

  // Handshake / advance
  logic s1_valid;
  logic s1_adv, s2_adv, out_hs;

  assign s2_adv     = ~Out_valid_o | Out_ready_i;
  assign s1_adv     = ~s1_valid | s2_adv;
  assign In_ready_o = s1_adv;
  assign out_hs     = Out_valid_o & Out_ready_i;

  // Stage 1 combinational: tininess, pre-overflow and right shift of tiny values
  logic [W_SH-1:0]  shamt_raw, shamt;
  logic             in_tiny, in_preof, shift_lost;
  logic [W_FGR-1:0] fgr_dn;
  logic [PARM_EXP-1:0] exp_dn;

  always_comb begin
    in_tiny   = Exp_i[W_EI-1] | (Exp_i == '0);
    in_preof  = ~Exp_i[W_EI-1] & (Exp_i >= EXP_OVF);
    // 1 - Exp_i; only meaningful when the exponent is tiny
    shamt_raw = W_SH'(1) - {Exp_i[W_EI-1], Exp_i};
    shamt     = (shamt_raw > W_SH'(W_MI)) ? W_SH'(W_MI) : shamt_raw;
    shift_lost = 1'b0;
    for (int unsigned i = 0; i < W_MI; i++) begin
      if (W_SH'(i) < shamt) shift_lost = shift_lost | Mant_i[i];
    end
    // hidden bit drops out of the stored field; it is 0 after any denormal shift
    fgr_dn = in_tiny ? W_FGR'(Mant_i >> shamt) : Mant_i[W_FGR-1:0];
    exp_dn = in_tiny ? '0 : Exp_i[PARM_EXP-1:0];
  end

  // Stage 1 register
  logic                s1_sign, s1_sticky, s1_tiny, s1_preof;
  logic                s1_zero, s1_inf, s1_nan, s1_inv;
  logic [PARM_EXP-1:0] s1_exp;
  logic [W_FGR-1:0]    s1_fgr;
  logic [PARM_RM-1:0]  s1_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sticky <= 1'b0;
      s1_tiny   <= 1'b0;
      s1_preof  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inv    <= 1'b0;
      s1_exp    <= '0;
      s1_fgr    <= '0;
      s1_rm     <= '0;
    end else if (s1_adv) begin
      s1_valid <= In_valid_i;
      if (In_valid_i) begin
        s1_sign   <= Sign_i;
        s1_sticky <= Sticky_i | (in_tiny & shift_lost);
        s1_tiny   <= in_tiny;
        s1_preof  <= in_preof;
        s1_zero   <= Zero_i;
        s1_inf    <= Inf_i;
        s1_nan    <= NaN_i;
        s1_inv    <= Invalid_i;
        s1_exp    <= exp_dn;
        s1_fgr    <= fgr_dn;
        s1_rm     <= Rounding_mode_i;
      end
    end
  end

  // Stage 2 combinational: rounding, overflow saturation, special priority
  logic [PARM_MANT-1:0] frac;
  logic                 g, r, inexact, up, ovf;
  logic [W_EF-1:0]      rnd;
  logic [W_RES-1:0]     inf_res, max_res, ovf_res, res_c;
  logic [4:0]           flags_c;

  always_comb begin
    frac    = s1_fgr[W_FGR-1:2];
    g       = s1_fgr[1];
    r       = s1_fgr[0];
    inexact = g | r | s1_sticky;
    case (s1_rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = inexact & s1_sign;
      RM_RUP:  up = inexact & ~s1_sign;
      RM_RMM:  up = g;
      default: up = g & (r | s1_sticky | frac[0]);
    endcase
    // carry from the fraction ripples into the exponent field
    rnd     = {s1_exp, frac} + W_EF'(up);
    ovf     = s1_preof | (rnd[W_EF-1:PARM_MANT] == EXP_ONES);
    inf_res = {s1_sign, EXP_ONES, PARM_MANT'(0)};
    max_res = {s1_sign, EXP_ONES - PARM_EXP'(1), {PARM_MANT{1'b1}}};
    case (s1_rm)
      RM_RTZ:  ovf_res = max_res;
      RM_RDN:  ovf_res = s1_sign ? inf_res : max_res;
      RM_RUP:  ovf_res = s1_sign ? max_res : inf_res;
      default: ovf_res = inf_res;
    endcase

    res_c   = {s1_sign, rnd};
    flags_c = {3'b000, s1_tiny & inexact, inexact};
    if (s1_inv) begin
      res_c   = {1'b0, EXP_ONES, QNAN_FRAC};
      flags_c = 5'b10000;
    end else if (s1_nan) begin
      res_c   = {1'b0, EXP_ONES, QNAN_FRAC};
      flags_c = 5'b00000;
    end else if (s1_inf) begin
      res_c   = inf_res;
      flags_c = 5'b00000;
    end else if (s1_zero) begin
      res_c   = {s1_sign, W_EF'(0)};
      flags_c = 5'b00000;
    end else if (ovf) begin
      res_c   = ovf_res;
      flags_c = 5'b00101;
    end
  end

  // Stage 2 / output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_valid_o <= 1'b0;
      Result_o    <= '0;
      Fflags_o    <= '0;
    end else if (s2_adv) begin
      Out_valid_o <= s1_valid;
      if (s1_valid) begin
        Result_o <= res_c;
        Fflags_o <= flags_c;
      end
    end
  end

  // Flag accumulator; a clear coinciding with a handshake keeps that beat's flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Fflags_acc_o <= '0;
    end else if (Fflags_clr_i) begin
      Fflags_acc_o <= out_hs ? Fflags_o : 5'b00000;
    end else if (out_hs) begin
      Fflags_acc_o <= Fflags_acc_o | Fflags_o;
    end
  end

endmodule

// File: tb/tb_norm_round_pipe.sv
// Bench for norm_round_pipe (EXP=8, MANT=23): directed steps plus a random
// stream checked against a value-level rounding model and flag accumulator.
module tb_norm_round_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        In_valid_i = 1'b0;
  logic        In_ready_o;
  logic        Sign_i = 1'b0;
  logic [9:0]  Exp_i = '0;
  logic [25:0] Mant_i = '0;
  logic        Sticky_i = 1'b0;
  logic [2:0]  Rounding_mode_i = '0;
  logic        Zero_i = 1'b0, Inf_i = 1'b0, NaN_i = 1'b0, Invalid_i = 1'b0;
  logic        Out_valid_o;
  logic        Out_ready_i = 1'b0;
  logic [31:0] Result_o;
  logic [4:0]  Fflags_o, Fflags_acc_o;
  logic        Fflags_clr_i = 1'b0;

  always #5 clk = ~clk;

  norm_round_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
    .Sign_i(Sign_i), .Exp_i(Exp_i), .Mant_i(Mant_i), .Sticky_i(Sticky_i),
    .Rounding_mode_i(Rounding_mode_i),
    .Zero_i(Zero_i), .Inf_i(Inf_i), .NaN_i(NaN_i), .Invalid_i(Invalid_i),
    .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
    .Result_o(Result_o), .Fflags_o(Fflags_o), .Fflags_acc_o(Fflags_acc_o),
    .Fflags_clr_i(Fflags_clr_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  exp_t exp_q[$];
  logic [4:0]  mod_acc = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res = '0;
  logic [4:0]  prev_fl = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: treat the operand as a real value, round by comparing the
  // discarded remainder against one half, then re-encode.
  function automatic exp_t model(input logic sgn, input int e, input logic [25:0] m,
                                 input logic st, input logic [2:0] rm,
                                 input logic inv, input logic nan, input logic inf, input logic zero);
    exp_t o;
    longint unsigned mm, q;
    int ee, sh, rem;
    bit tiny, stk, inexact, up, above, tie, to_inf;
    o.res = 32'h0;
    o.fl  = 5'h0;
    to_inf = (rm == 3'd2) ? sgn : (rm == 3'd3) ? !sgn : (rm != 3'd1);
    if (inv) begin o.res = 32'h7FC0_0000; o.fl = 5'b10000; return o; end
    if (nan) begin o.res = 32'h7FC0_0000; return o; end
    if (inf) begin o.res = {sgn, 8'hFF, 23'h0}; return o; end
    if (zero) begin o.res = {sgn, 31'h0}; return o; end
    if (e >= 255) begin
      o.res = to_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF};
      o.fl  = 5'b00101;
      return o;
    end
    mm = 64'(m); ee = e; stk = st; tiny = 0;
    if (e <= 0) begin
      sh = 1 - e;
      if (sh > 26) sh = 26;
      if ((mm % (64'd1 << sh)) != 0) stk = 1;
      mm = mm >> sh;
      ee = 0;
      tiny = 1;
    end
    q   = mm >> 2;
    rem = int'(mm & 64'd3);
    above   = (rem == 3) || (rem == 2 && stk);
    tie     = (rem == 2) && !stk;
    inexact = (rem != 0) || stk;
    case (rm)
      3'd1: up = 0;
      3'd2: up = inexact && sgn;
      3'd3: up = inexact && !sgn;
      3'd4: up = above || tie;
      default: up = above || (tie && q[0]);
    endcase
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin q = 64'd1 << 23; ee++; end
    else if (ee == 0 && q >= (64'd1 << 23)) ee = 1;
    if (ee >= 255) begin
      o.res = to_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF};
      o.fl  = 5'b00101;
    end else begin
      o.res = {sgn, 8'(ee), 23'(q)};
      o.fl  = {3'b000, tiny && inexact, inexact};
    end
    return o;
  endfunction

  // Stream monitor: sampled on the falling edge, between active edges
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      mod_acc    = '0;
      prev_stall = 1'b0;
    end else begin
      check("acc", 32'(Fflags_acc_o), 32'(mod_acc));
      if (prev_stall) begin
        check("hold_valid", 32'(Out_valid_o), 32'(1));
        check("hold_res", Result_o, prev_res);
        check("hold_flags", 32'(Fflags_o), 32'(prev_fl));
      end
      if (Out_valid_o && Out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(Out_valid_o), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("res", Result_o, e.res);
          check("flags", 32'(Fflags_o), 32'(e.fl));
          n_out++;
          mod_acc = Fflags_clr_i ? e.fl : (mod_acc | e.fl);
        end
      end else if (Fflags_clr_i) begin
        mod_acc = '0;
      end
      prev_stall = Out_valid_o & ~Out_ready_i;
      prev_res   = Result_o;
      prev_fl    = Fflags_o;
      if (In_valid_i && In_ready_o)
        exp_q.push_back(model(Sign_i, int'($signed(Exp_i)), Mant_i, Sticky_i, Rounding_mode_i,
                              Invalid_i, NaN_i, Inf_i, Zero_i));
    end
  end

  task automatic drive(input logic sgn, input int e, input logic [25:0] m, input logic st,
                       input logic [2:0] rm, input logic [3:0] sp);
    Sign_i = sgn; Exp_i = 10'(e); Mant_i = m; Sticky_i = st; Rounding_mode_i = rm;
    {Invalid_i, NaN_i, Inf_i, Zero_i} = sp;
  endtask

  // One beat through an empty pipe; optional clear in the handshake cycle
  task automatic run_beat(input logic sgn, input int e, input logic [25:0] m, input logic st,
                          input logic [2:0] rm, input logic [3:0] sp, input bit clr_on_out,
                          output logic [31:0] res, output logic [4:0] fl, output int lat);
    drive(sgn, e, m, st, rm, sp);
    In_valid_i = 1'b1; Out_ready_i = 1'b1;
    @(posedge clk); #1;
    In_valid_i = 1'b0;
    lat = 1;
    while (!Out_valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = Result_o; fl = Fflags_o;
    if (clr_on_out) Fflags_clr_i = 1'b1;
    @(posedge clk); #1;
    Fflags_clr_i = 1'b0;
  endtask

  task automatic rand_beat();
    int e;
    logic [25:0] m;
    case ($urandom_range(0, 9))
      5: e = int'($urandom_range(250, 254));
      6: e = -int'($urandom_range(0, 30));
      7: e = -int'($urandom_range(20, 512));
      8: e = int'($urandom_range(255, 511));
      default: e = int'($urandom_range(1, 254));
    endcase
    m = {1'b1, 25'($urandom)};
    if ($urandom_range(0, 4) == 0) m[25:2] = '1;
    drive(1'($urandom), e, m, 1'($urandom), 3'($urandom_range(0, 7)),
          {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [4:0]  fl;
    int lat, idx, n0, guard;
    bit have;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(Out_valid_o), 32'(0));
    check("rst_in_ready", 32'(In_ready_o), 32'(1));
    check("rst_result", Result_o, 32'h0);
    check("rst_flags", 32'(Fflags_o), 32'(0));
    check("rst_acc", 32'(Fflags_acc_o), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact value and latency
    run_beat(1'b0, 127, 26'h200_0000, 1'b0, 3'd0, 4'b0, 0, res, fl, lat);
    check("exact_res", res, 32'h3F80_0000);
    check("exact_flags", 32'(fl), 32'(0));
    check("exact_latency", 32'(lat), 32'(2));

    // Rounding carry into the exponent, and truncation of the same beat
    run_beat(1'b0, 127, 26'h3FF_FFFE, 1'b0, 3'd0, 4'b0, 0, res, fl, lat);
    check("carry_rne_res", res, 32'h4000_0000);
    check("carry_rne_flags", 32'(fl), 32'(5'h01));
    run_beat(1'b0, 127, 26'h3FF_FFFE, 1'b0, 3'd1, 4'b0, 0, res, fl, lat);
    check("carry_rtz_res", res, 32'h3FFF_FFFF);
    check("carry_rtz_flags", 32'(fl), 32'(5'h01));

    // Ties: RNE keeps the even value, RMM rounds away
    run_beat(1'b0, 127, 26'h200_0002, 1'b0, 3'd0, 4'b0, 0, res, fl, lat);
    check("tie_rne_res", res, 32'h3F80_0000);
    run_beat(1'b0, 127, 26'h200_0002, 1'b0, 3'd4, 4'b0, 0, res, fl, lat);
    check("tie_rmm_res", res, 32'h3F80_0001);

    // Overflow per mode
    run_beat(1'b1, 255, 26'h200_0000, 1'b0, 3'd0, 4'b0, 0, res, fl, lat);
    check("ovf_rne_res", res, 32'hFF80_0000);
    check("ovf_rne_flags", 32'(fl), 32'(5'h05));
    run_beat(1'b1, 255, 26'h200_0000, 1'b0, 3'd1, 4'b0, 0, res, fl, lat);
    check("ovf_rtz_res", res, 32'hFF7F_FFFF);
    run_beat(1'b1, 255, 26'h200_0000, 1'b0, 3'd3, 4'b0, 0, res, fl, lat);
    check("ovf_rup_res", res, 32'hFF7F_FFFF);
    run_beat(1'b1, 255, 26'h200_0000, 1'b0, 3'd2, 4'b0, 0, res, fl, lat);
    check("ovf_rdn_res", res, 32'hFF80_0000);
    // Max finite rounding up into overflow
    run_beat(1'b0, 254, 26'h3FF_FFFE, 1'b0, 3'd0, 4'b0, 0, res, fl, lat);
    check("round_ovf_res", res, 32'h7F80_0000);
    check("round_ovf_flags", 32'(fl), 32'(5'h05));

    // Denormals
    run_beat(1'b0, -1, 26'h200_0000, 1'b0, 3'd0, 4'b0, 0, res, fl, lat);
    check("denorm_res", res, 32'h0020_0000);
    check("denorm_flags", 32'(fl), 32'(0));
    run_beat(1'b0, -1, 26'h200_0000, 1'b1, 3'd3, 4'b0, 0, res, fl, lat);
    check("denorm_rup_res", res, 32'h0020_0001);
    check("denorm_rup_flags", 32'(fl), 32'(5'h03));

    // Specials and their priority
    run_beat(1'b0, 127, 26'h200_0000, 1'b0, 3'd0, 4'b0100, 0, res, fl, lat);
    check("nan_res", res, 32'h7FC0_0000);
    check("nan_flags", 32'(fl), 32'(0));
    run_beat(1'b1, 127, 26'h200_0000, 1'b0, 3'd0, 4'b0011, 0, res, fl, lat);
    check("inf_over_zero_res", res, 32'hFF80_0000);
    run_beat(1'b1, 127, 26'h200_0000, 1'b1, 3'd0, 4'b0001, 0, res, fl, lat);
    check("zero_res", res, 32'h8000_0000);
    check("zero_flags", 32'(fl), 32'(0));

    // Backpressure: two-deep capacity, output held while stalled
    Out_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) drive(1'b0, 127 + idx, 26'h200_0000, 1'b0, 3'd0, 4'b0);
      In_valid_i = (idx < 3);
      @(negedge clk);
      if (In_valid_i && In_ready_o) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", 32'(idx), 32'(2));
    check("bp_in_ready", 32'(In_ready_o), 32'(0));
    check("bp_head_res", Result_o, 32'h3F80_0000);
    n0 = n_out;
    Out_ready_i = 1'b1;
    guard = 0;
    while (idx < 3 && guard < 10) begin
      drive(1'b0, 127 + idx, 26'h200_0000, 1'b0, 3'd0, 4'b0);
      In_valid_i = 1'b1;
      @(negedge clk);
      if (In_ready_o) idx++;
      @(posedge clk); #1;
      guard++;
    end
    In_valid_i = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("bp_out_count", 32'(n_out - n0), 32'(3));

    // Accumulator
    Fflags_clr_i = 1'b1;
    @(posedge clk); #1;
    Fflags_clr_i = 1'b0;
    check("acc_cleared", 32'(Fflags_acc_o), 32'(0));
    run_beat(1'b1, 127, 26'h200_0000, 1'b0, 3'd0, 4'b1000, 0, res, fl, lat);
    check("inv_res", res, 32'h7FC0_0000);
    check("inv_flags", 32'(fl), 32'(5'h10));
    check("acc_nv", 32'(Fflags_acc_o), 32'(5'h10));
    run_beat(1'b0, 127, 26'h3FF_FFFE, 1'b0, 3'd0, 4'b0, 0, res, fl, lat);
    check("acc_nv_nx", 32'(Fflags_acc_o), 32'(5'h11));
    run_beat(1'b0, 127, 26'h3FF_FFFE, 1'b0, 3'd0, 4'b0, 1, res, fl, lat);
    check("acc_clr_with_hs", 32'(Fflags_acc_o), 32'(5'h01));

    // Reset with two beats in flight
    Out_ready_i = 1'b0;
    drive(1'b0, 127, 26'h200_0000, 1'b0, 3'd0, 4'b0);
    In_valid_i = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 128, 26'h200_0000, 1'b1, 3'd0, 4'b0);
    @(posedge clk); #1;
    In_valid_i = 1'b0;
    check("inflight_valid", 32'(Out_valid_o), 32'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(Out_valid_o), 32'(0));
    check("midrst_acc", 32'(Fflags_acc_o), 32'(0));
    check("midrst_in_ready", 32'(In_ready_o), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    Out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("post_rst_idle", 32'(Out_valid_o), 32'(0));
    end

    // Random stream with random handshakes and clears
    have = 0;
    for (int c = 0; c < 500; c++) begin
      if (!have) begin rand_beat(); have = 1; end
      In_valid_i   = ($urandom_range(0, 3) != 0);
      Out_ready_i  = ($urandom_range(0, 3) != 0);
      Fflags_clr_i = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (In_valid_i && In_ready_o) have = 0;
      @(posedge clk); #1;
    end
    In_valid_i = 1'b0; Out_ready_i = 1'b1; Fflags_clr_i = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
